i2c_cfg_sequencer: RTL

I2C_CFG_SEQUENCER -- requirements
Module: i2c_cfg_sequencer

---
 rtl/i2c_cfg_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a register table and issues one I2C write per entry,
// retrying NACKed writes and settling between transactions.
module i2c_cfg_sequencer #(
   parameter logic [6:0] SLAVE_ADDR = 7'h3C,
   parameter int         IDX_W      = 6,
   parameter int         MAX_RETRY  = 3,
   parameter int         SETTLE_CYC = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W-1:0] tbl_len,
   output logic [IDX_W-1:0] tbl_idx,
   input  logic [15:0]      tbl_data,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic             m_req,
   output logic             m_rw,
   output logic [6:0]       m_slave_addr,
   output logic [7:0]       m_reg,
   output logic [7:0]       m_wdata,
   input  logic             m_rsp_valid,
   input  logic             m_rsp_nack
);
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam int CW = $clog2(SETTLE_CYC + 1);
   localparam logic [RW-1:0] MAX_R  = RW'(MAX_RETRY);
   localparam logic [CW-1:0] LAST_C = CW'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, SETTLE, END} state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_len;
   logic [RW-1:0]    r_retry;
   logic [CW-1:0]    r_cnt;
   logic             w_last;

   assign m_rw         = 1'b0;
   assign m_slave_addr = SLAVE_ADDR;
   assign w_last       = tbl_idx == r_len - 1'b1;

   // A nonzero retry count doubles as the "re-issue pending" flag, since an ACK clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_len   <= '0;
         r_retry <= '0;
         r_cnt   <= '0;
         tbl_idx <= '0;
         m_reg   <= '0;
         m_wdata <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
         m_req   <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (r_state)
            IDLE: if (start) begin
               if (tbl_len != '0) begin
                  r_len   <= tbl_len;
                  tbl_idx <= '0;
                  r_retry <= '0;
                  busy    <= 1'b1;
                  r_state <= FETCH;
               end else done <= 1'b1;
            end
            FETCH: if (tbl_data == 16'hFFFF) begin
               done    <= 1'b1;
               r_state <= END;
            end else begin
               m_reg   <= tbl_data[15:8];
               m_wdata <= tbl_data[7:0];
               m_req   <= 1'b1;
               r_state <= ISSUE;
            end
            ISSUE: if (m_rsp_valid) begin
               m_req <= 1'b0;
               r_cnt <= '0;
               if (!m_rsp_nack) begin
                  r_retry <= '0;
                  r_state <= SETTLE;
               end else if (r_retry < MAX_R) begin
                  r_retry <= r_retry + 1'b1;
                  r_state <= SETTLE;
               end else begin
                  r_retry <= '0;
                  error   <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end
            end
            SETTLE: if (r_cnt == LAST_C) begin
               if (r_retry != '0) begin
                  m_req   <= 1'b1;
                  r_state <= ISSUE;
               end else if (w_last) begin
                  done    <= 1'b1;
                  r_state <= END;
               end else begin
                  tbl_idx <= tbl_idx + 1'b1;
                  r_state <= FETCH;
               end
            end else r_cnt <= r_cnt + 1'b1;
            END: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
